// File: rtl/nios_pio_in_edge.sv
// nios_pio_in_edge: Avalon-MM PIO input port with synchroniser, per-bit debounce and edge-capture interrupt.
module nios_pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync, db, prev, irqmask, edgecapture, edge_hit, clr, rd_mux;
    logic             wr;
    logic             unused_wd;
    assign unused_wd = ^writedata;
    assign sync      = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    for (genvar b = 0; b < WIDTH; b++) begin : g_db
        logic [CW-1:0] cnt;
        logic          db_q;
        assign db[b] = db_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt  <= '0;
                db_q <= 1'b0;
            end else if (sync[b] == db_q) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt  <= '0;
                db_q <= sync[b];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
    assign edge_hit = (EDGE_TYPE == 0) ? (db & ~prev) :
                      (EDGE_TYPE == 1) ? (~db & prev) : (db ^ prev);
    assign wr       = chipselect & ~write_n;
    assign clr      = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign rd_mux   = (address == 2'd0) ? db :
                      (address == 2'd1) ? sync :
                      (address == 2'd2) ? irqmask : edgecapture;
    // A new edge is OR-ed in after the clear so it survives a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            prev        <= db;
            irqmask     <= (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask;
            edgecapture <= (edgecapture & ~clr) | edge_hit;
            readdata    <= 32'(rd_mux);
        end
    end
    assign irq = |(edgecapture & irqmask);
endmodule

// File: doc/nios_pio_in_edge.md
NIOS_PIO_IN_EDGE -- requirements
Module: nios_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 8: input port width, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth, legal 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1: consecutive stable cycles required before the debounced value follows, legal 1..65535.
REQ-004 Parameter EDGE_TYPE, default 0: capture mode, 0 rising, 1 falling, 2 any edge.
REQ-005 clk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset, sampled on rising clk.
REQ-007 address  in  2  Avalon-MM word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 write_n  in  1  active-low write strobe.
REQ-010 writedata  in  32  write data; bits above WIDTH-1 ignored.
REQ-011 in_port  in  WIDTH  asynchronous external inputs.
REQ-012 readdata  out  32  registered read data, zero-extended above WIDTH-1.
REQ-013 irq  out  1  level interrupt request.

Function
REQ-014 Register map SHALL be: 0 debounced data (RO), 1 raw synchronised data (RO), 2 irqmask (RW), 3 edgecapture (read; write-1-to-clear).
REQ-015 in_port SHALL pass through SYNC_STAGES flops per bit; last stage is the "sync" value.
REQ-016 Per bit, a counter SHALL increment while sync differs from debounced; on the cycle it would reach DEBOUNCE_CYCLES, debounced SHALL load sync and the counter clear; counter SHALL clear whenever sync equals debounced.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change debounced.
REQ-018 A prev register SHALL load debounced every cycle; edge detect per bit: rising = db & ~prev, falling = ~db & prev, any = db ^ prev, selected by EDGE_TYPE.
REQ-019 A detected edge SHALL set its edgecapture bit on the next clk edge; bit stays set until cleared.
REQ-020 Write effective when chipselect=1 and write_n=0; address 2 loads irqmask; address 3 clears edgecapture bits where writedata bit is 1; writes to 0/1 ignored.
REQ-021 Simultaneous edge and write-1-clear on the same bit: set SHALL win.
REQ-022 readdata SHALL update every cycle from address, independent of chipselect: latency one cycle; reading edgecapture SHALL NOT clear it.
REQ-023 irq SHALL equal OR of (edgecapture & irqmask), derived from registers only, no added latency.
REQ-024 Latency with SYNC_STAGES=S, DEBOUNCE_CYCLES=N: in_port change to debounced = S+N edges; edgecapture one edge later; readdata one edge after the register.

Reset
REQ-025 On reset: readdata, irqmask, edgecapture, sync flops, counters, debounced, prev SHALL all be 0.
REQ-026 Reset SHALL override any concurrent write or edge; an in-flight debounce count SHALL be discarded.
REQ-027 An input held high through reset SHALL produce a rising-edge capture S+N+1 edges after reset release (documented, software clears).

Verification
REQ-028 Defaults, reset, in_port 8'h00->8'h05 held, address 0 -> readdata 32'h5 at edge 4 after change; address 3 -> 32'h5 at edge 5.
REQ-029 N=4, bit0 pulse high 3 cycles -> debounced and edgecapture stay 0; pulse 4 cycles -> edgecapture bit0 =1.
REQ-030 irqmask=8'h01, edge on bit1 -> irq 0; edge on bit0 -> irq 1; write 32'h1 to address 3 -> irq 0 next cycle.
REQ-031 Edge on bit2 in the same cycle as write 32'h4 to address 3 -> edgecapture bit2 remains 1.
REQ-032 EDGE_TYPE=1, bit3 1->0 -> capture; 0->1 -> none; EDGE_TYPE=2 both capture.
REQ-033 Assert reset mid-debounce with edgecapture=8'hFF, irqmask=8'hFF -> all registers 0, irq 0 the next cycle.
